// File: rtl/spi_aes_sequencer.sv
// Runs one AES job over a byte-level SPI master: command, key, plaintext, then a
// 16-byte ciphertext readback. Owns chip-select timing, byte order and abort.
module spi_aes_sequencer #(
    parameter int         CS_SETUP   = 2,
    parameter int         CS_HOLD    = 2,
    parameter int         GAP_CYCLES = 1,
    parameter logic [7:0] CMD_BASE   = 8'hA0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [1:0]   size,
    input  logic [255:0] key_in,
    input  logic [127:0] data_in,
    output logic         byte_start,
    output logic [7:0]   byte_tx,
    input  logic         byte_done,
    input  logic [7:0]   byte_rx,
    output logic         cs_n,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [127:0] data_out
);
    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_CMD, S_KEY, S_DATA, S_READ, S_GAP, S_HOLD, S_DONE, S_ERROR
    } state_t;

    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

    state_t           state, state_nx;
    logic             en_low, start, abort_r, aborting, in_byte, in_active, last, issue;
    logic [1:0]       size_r, ph, ph_nx, iss_ph;
    logic [4:0]       idx, idx_nx, iss_idx;
    logic [5:0]       len;
    logic [7:0]       cnt, tx_nx;
    logic [31:0][7:0] key_r;
    logic [15:0][7:0] data_r;
    logic [127:0]     shreg;

    function automatic state_t phase_state(input logic [1:0] p);
        case (p)
            2'd0:    return S_CMD;
            2'd1:    return S_KEY;
            2'd2:    return S_DATA;
            default: return S_READ;
        endcase
    endfunction

    assign in_byte   = state inside {S_CMD, S_KEY, S_DATA, S_READ};
    assign in_active = in_byte || (state inside {S_SETUP, S_GAP});
    // en_low resets to 0 so a level held high across reset release is not an edge
    assign start     = (state == S_IDLE) && enable && en_low;
    assign aborting  = abort_r || !enable;
    assign issue     = (state_nx inside {S_CMD, S_KEY, S_DATA, S_READ}) && (!in_byte || byte_done);

    // ph/idx name the byte in flight, or in GAP the byte about to be sent
    always_comb begin
        case (ph)
            2'd0:    len = 6'd1;
            2'd1:    len = 6'd16 + {1'b0, size_r, 3'b000};
            default: len = 6'd16;
        endcase
        last    = ({1'b0, idx} == len - 6'd1);
        ph_nx   = last ? ph + 2'd1 : ph;
        idx_nx  = last ? 5'd0 : idx + 5'd1;
        iss_ph  = in_byte ? ph_nx : ph;
        iss_idx = in_byte ? idx_nx : idx;
        case (iss_ph)
            2'd0:    tx_nx = CMD_BASE | {6'b0, size_r};
            2'd1:    tx_nx = key_r[5'd31 - iss_idx];
            2'd2:    tx_nx = data_r[4'd15 - iss_idx[3:0]];
            default: tx_nx = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = (size == 2'b11) ? S_ERROR : S_SETUP;
            S_SETUP: begin
                if (!enable)                 state_nx = S_HOLD;
                else if (cnt == SETUP_LAST)  state_nx = S_CMD;
            end
            S_CMD, S_KEY, S_DATA, S_READ: begin
                if (byte_done) begin
                    if (aborting || (ph == 2'd3 && last)) state_nx = S_HOLD;
                    else if (GAP_CYCLES == 0)             state_nx = phase_state(ph_nx);
                    else                                  state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (!enable)              state_nx = S_HOLD;
                else if (cnt == GAP_LAST) state_nx = phase_state(ph);
            end
            S_HOLD:  if (cnt == HOLD_LAST) state_nx = abort_r ? S_ERROR : S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cs_n = 1'b1;
        busy = 1'b0;
        done = 1'b0;
        if (in_active || state == S_HOLD) begin
            cs_n = 1'b0;
            busy = 1'b1;
        end
        if (state == S_DONE) done = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_low     <= 1'b0;
            abort_r    <= 1'b0;
            size_r     <= '0;
            key_r      <= '0;
            data_r     <= '0;
            shreg      <= '0;
            ph         <= '0;
            idx        <= '0;
            cnt        <= '0;
            byte_start <= 1'b0;
            byte_tx    <= '0;
            err        <= 1'b0;
            data_out   <= '0;
        end else begin
            en_low     <= !enable;
            byte_start <= issue;
            cnt        <= (state_nx != state) ? 8'd0 : cnt + 8'd1;
            if (issue) byte_tx <= tx_nx;
            if (in_active && !enable) abort_r <= 1'b1;
            if (start) begin
                err     <= 1'b0;
                abort_r <= 1'b0;
                size_r  <= size;
                key_r   <= key_in;
                data_r  <= data_in;
                ph      <= '0;
                idx     <= '0;
            end
            if (in_byte && byte_done) begin
                ph  <= ph_nx;
                idx <= idx_nx;
                if (state == S_READ) shreg <= {shreg[119:0], byte_rx};
            end
            if (state_nx == S_ERROR) err <= 1'b1;
            if (state_nx == S_DONE)  data_out <= shreg;
        end
    end
endmodule
